seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display bank. It latches a packed BCD/hex value with per-digit decimal points and scans one digit at a time at a programmable rate. It also blanks leading zeros and applies new values only at frame boundaries, so the display never shows a mixed old/new value. It sits between the counter/datapath logic and the board display pins, replacing the single-digit combinational decoder.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns and the digit-code decode used by the scan driver.
// Patterns are {a,b,c,d,e,f,g}, logical 1 = lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_B    = 7'b0011111;
  localparam logic [6:0] SEG_C    = 7'b1001110;
  localparam logic [6:0] SEG_D    = 7'b0111101;
  localparam logic [6:0] SEG_E    = 7'b1001111;
  localparam logic [6:0] SEG_F    = 7'b1000111;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Codes 10..15 become a dash unless hex rendering is enabled.
  function automatic logic [6:0] seg7_decode_code(input logic [3:0] code,
                                                  input logic       hex_en);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_en ? SEG_A : SEG_DASH;
      4'd11: seg = hex_en ? SEG_B : SEG_DASH;
      4'd12: seg = hex_en ? SEG_C : SEG_DASH;
      4'd13: seg = hex_en ? SEG_D : SEG_DASH;
      4'd14: seg = hex_en ? SEG_E : SEG_DASH;
      default: seg = hex_en ? SEG_F : SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit code to {a..g} decoder.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_decode_code(code_i, HEX_EN);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: pending/shadow value registers updated
// at frame boundaries, leading-zero blanking, registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 100000,
  parameter bit HEX_EN         = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  input  logic                  blank_lz_i,
  input  logic                  en_i,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_IDLE   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_IDLE    = AN_ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, shd_val_q, shd_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic                wrap_q, wrap_d, frame_q, frame_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tc, boundary, upper_nz, blank;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic [6:0]          dec_seg;
  logic [7:0]          seg_logic;
  logic [DIGITS-1:0]   an_logic;

  seg7_decode #(.HEX_EN(HEX_EN)) u_decode (
    .code_i (cur_code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    tc       = (presc_q == PRESC_LAST);
    boundary = tc && (idx_q == IDX_LAST);
    presc_d  = tc ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load coinciding with the boundary belongs to the next frame.
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (pend_vld_q) begin
        shd_val_d = pend_val_q;
        shd_dp_d  = pend_dp_q;
      end
    end
    if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      pend_vld_d = 1'b1;
    end

    wrap_d  = boundary;
    frame_d = wrap_q;

    cur_code = 4'd0;
    cur_dp   = 1'b0;
    upper_nz = 1'b0;
    an_logic = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_code    = shd_val_q[4*k +: 4];
        cur_dp      = shd_dp_q[k];
        an_logic[k] = 1'b1;
      end
      if ((k >= int'(idx_q)) && (shd_val_q[4*k +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    blank     = blank_lz_i && !upper_nz && (idx_q != '0);
    seg_logic = {(blank ? SEG_OFF : dec_seg), cur_dp};
    if (!en_i) begin
      seg_logic = 8'h00;
      an_logic  = '0;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_logic : seg_logic;
    an_d  = AN_ACTIVE_LOW ? ~an_logic : an_logic;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      wrap_q     <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SEG_IDLE;
      an_q       <= AN_IDLE;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      wrap_q     <= wrap_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        blank_lz_i;
  logic        en_i;
  logic [7:0]  seg_o, seg_hex;
  logic [3:0]  an_o, an_hex;
  logic        frame_o, frame_hex;

  int tests  = 0;
  int failed = 0;

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .en_i(en_i), .seg_o(seg_o), .an_o(an_o), .frame_o(frame_o)
  );

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .load_i(load_i),
    .blank_lz_i(blank_lz_i), .en_i(en_i), .seg_o(seg_hex), .an_o(an_hex), .frame_o(frame_hex)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next frame pulse, then checks every digit of that frame.
  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_s[4];
    logic [3:0] exp_an;
    logic       found;
    logic [7:0] extra;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    found = 1'b0;
    extra = 8'd0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_o) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("%s_frame_seen", tag), {7'b0, found}, 8'd1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i % 4 == 0) begin
          exp_an = ~(4'b0001 << (i / 4));
          chk($sformatf("%s_d%0d_an", tag, i / 4), {4'h0, an_o}, {4'h0, exp_an});
          chk($sformatf("%s_d%0d_seg", tag, i / 4), seg_o, exp_s[i / 4]);
        end
        if (i > 0 && frame_o) extra++;
        if (i < 15) step();
      end
      chk($sformatf("%s_frame_once", tag), extra, 8'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; value_i = 16'h0; dp_i = 4'h0; load_i = 1'b0;
    blank_lz_i = 1'b0; en_i = 1'b1;

    // reset state
    repeat (2) step();
    chk("reset_an", {4'h0, an_o}, 8'b0000_1111);
    chk("reset_seg", seg_o, 8'b0000_0000);
    chk("reset_frame", {7'b0, frame_o}, 8'd0);

    // release: digit 0 of zero shadow, each anode held 4 cycles
    rst_n = 1'b1;
    step();
    chk("rel_an", {4'h0, an_o}, 8'b0000_1110);
    chk("rel_seg", seg_o, 8'b1111_1100);
    chk("rel_frame", {7'b0, frame_o}, 8'd0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk($sformatf("hold_e%0d_an", i), {4'h0, an_o}, (i <= 4) ? 8'b0000_1110 : 8'b0000_1101);
    end

    // mid-frame load of 1234 with dp on digit 1; old value persists to frame end
    step();
    value_i = 16'h1234; dp_i = 4'b0010; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0; dp_i = 4'h0;
    step();
    chk("old_mid_an", {4'h0, an_o}, 8'b0000_1101);
    chk("old_mid_seg", seg_o, 8'b1111_1100);
    repeat (8) step();
    chk("old_end_an", {4'h0, an_o}, 8'b0000_0111);
    chk("old_end_seg", seg_o, 8'b1111_1100);
    check_frame("v1234", 8'b0110_0110, 8'b1111_0011, 8'b1101_1010, 8'b0110_0000);

    // leading-zero blanking
    blank_lz_i = 1'b1; value_i = 16'h0070; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0;
    check_frame("lz0070", 8'b1111_1100, 8'b1110_0000, 8'b0000_0000, 8'b0000_0000);
    value_i = 16'h0000; dp_i = 4'b1000; load_i = 1'b1;
    step();
    load_i = 1'b0; dp_i = 4'h0;
    check_frame("lz0000", 8'b1111_1100, 8'b0000_0000, 8'b0000_0000, 8'b0000_0001);

    // code B: dash without hex, 'b' with hex
    blank_lz_i = 1'b0; value_i = 16'h000B; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0;
    check_frame("code_b", 8'b0000_0010, 8'b1111_1100, 8'b1111_1100, 8'b1111_1100);
    step();
    chk("hex_b_seg", seg_hex, 8'b0011_1110);
    chk("hex_b_an", {4'h0, an_hex}, 8'b0000_1110);
    chk("dash_b_seg", seg_o, 8'b0000_0010);

    // back-to-back loads: last wins
    value_i = 16'h1111; load_i = 1'b1;
    step();
    value_i = 16'h2222;
    step();
    load_i = 1'b0; value_i = 16'h0;
    check_frame("last_wins", 8'b1101_1010, 8'b1101_1010, 8'b1101_1010, 8'b1101_1010);

    // load early in a frame, then another on the boundary edge itself
    value_i = 16'h9999; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0;
    repeat (14) step();
    value_i = 16'h5678; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0;
    chk("bnd_no_frame_yet", {7'b0, frame_o}, 8'd0);
    check_frame("pre_bnd", 8'b1111_0110, 8'b1111_0110, 8'b1111_0110, 8'b1111_0110);
    check_frame("coincident", 8'b1111_1110, 8'b1110_0000, 8'b1011_1110, 8'b1011_0110);

    // enable off mid-frame, then resume with phase preserved
    repeat (5) step();
    chk("pre_en_an", {4'h0, an_o}, 8'b0000_1101);
    en_i = 1'b0;
    step();
    chk("en_off_an", {4'h0, an_o}, 8'b0000_1111);
    chk("en_off_seg", seg_o, 8'b0000_0000);
    step();
    chk("en_off2_an", {4'h0, an_o}, 8'b0000_1111);
    en_i = 1'b1;
    step();
    chk("en_on_an", {4'h0, an_o}, 8'b0000_1101);
    chk("en_on_seg", seg_o, 8'b1110_0000);
    step();
    chk("en_next_an", {4'h0, an_o}, 8'b0000_1011);
    chk("en_next_seg", seg_o, 8'b1011_1110);

    // reset pulse mid-frame drops pending and scan position
    value_i = 16'h1111; load_i = 1'b1;
    step();
    load_i = 1'b0; value_i = 16'h0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_an", {4'h0, an_o}, 8'b0000_1111);
    chk("mid_rst_seg", seg_o, 8'b0000_0000);
    chk("mid_rst_frame", {7'b0, frame_o}, 8'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_an", {4'h0, an_o}, 8'b0000_1110);
    chk("post_rst_seg", seg_o, 8'b1111_1100);
    check_frame("post_rst", 8'b1111_1100, 8'b1111_1100, 8'b1111_1100, 8'b1111_1100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
